// File: rtl/leddc_pkg.sv
// Shared types and constants for the LED display driver data path.
package leddc_pkg;

  localparam int LEDDC_WORD_W          = 16;
  localparam int LEDDC_CHANNELS        = 16;
  localparam int LEDDC_SCANLINES       = 32;
  localparam int LEDDC_WORDS_PER_FRAME = LEDDC_CHANNELS * LEDDC_SCANLINES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_FGAP  = 2'd3
  } ser_state_t;

  // A word's end-of-frame marker must agree with its position in the frame.
  function automatic logic frame_mismatch(input logic last_mark, input logic at_frame_end);
    return last_mark ^ at_frame_end;
  endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry holding register between the frame source and the serializer.
module ser_hold_reg
  import leddc_pkg::*;
#(
  parameter int W = LEDDC_WORD_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic [W-1:0] dout
);

  logic         full_r;
  logic [W-1:0] data_r;

  // Capture on push; a push in the same cycle as a pop refills the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r <= 1'b0;
      data_r <= '0;
    end else if (push) begin
      full_r <= 1'b1;
      data_r <= din;
    end else if (pop) begin
      full_r <= 1'b0;
    end
  end

  assign full = full_r;
  assign dout = data_r;

endmodule

// File: rtl/led_data_serializer.sv
// Serializes 16-bit grayscale words LSB-first onto DAI, framed by DEN,
// with inter-word and frame gaps and a fixed-length frame alignment check.
module led_data_serializer
  import leddc_pkg::*;
#(
  parameter int WORD_W          = LEDDC_WORD_W,
  parameter int WORDS_PER_FRAME = LEDDC_WORDS_PER_FRAME,
  parameter int GAP_CYC         = 2,
  parameter int FRAME_GAP_CYC   = 4
) (
  input  logic                               DCK,
  input  logic                               rst_n,
  input  logic                               in_valid,
  input  logic [WORD_W-1:0]                  in_data,
  input  logic                               in_last,
  output logic                               in_ready,
  output logic                               DAI,
  output logic                               DEN,
  output logic                               frame_done,
  output logic [$clog2(WORDS_PER_FRAME)-1:0] word_cnt,
  output logic                               sync_err
);

  localparam int CNT_W  = $clog2(WORDS_PER_FRAME);
  localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int GMAX   = (GAP_CYC > FRAME_GAP_CYC) ? GAP_CYC : FRAME_GAP_CYC;
  localparam int GCNT_W = (GMAX > 1) ? $clog2(GMAX + 1) : 1;

  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(WORDS_PER_FRAME - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);
  localparam logic [GCNT_W-1:0] GAP_LAST  = GCNT_W'(GAP_CYC - 1);
  localparam logic [GCNT_W-1:0] FGAP_LAST = GCNT_W'(FRAME_GAP_CYC - 1);

  ser_state_t          state_r;
  logic [WORD_W-1:0]   shift_r;
  logic [BIT_W-1:0]    bit_cnt_r;
  logic [GCNT_W-1:0]   gap_cnt_r;
  logic [CNT_W-1:0]    word_cnt_r;
  logic                den_r;
  logic                dai_r;
  logic                fgap_exit_r;
  logic                frame_done_r;
  logic                sync_err_r;

  logic                hold_full_s;
  logic [WORD_W:0]     hold_dout_s;
  logic [WORD_W-1:0]   hold_word_s;
  logic                hold_last_s;
  logic                push_s;
  logic                pop_s;
  logic                idle_s;
  logic                advance_s;
  logic                to_fgap_s;
  logic                frame_end_s;
  logic [CNT_W-1:0]    load_idx_s;

  assign hold_word_s = hold_dout_s[WORD_W:1];
  assign hold_last_s = hold_dout_s[0];

  // The entry can be refilled in the same cycle it is loaded into the shifter;
  // rst_n gating keeps ready low while reset is held.
  assign in_ready = rst_n & (~hold_full_s | pop_s);
  assign push_s   = in_valid & in_ready;

  ser_hold_reg #(
    .W (WORD_W + 1)
  ) u_hold (
    .clk   (DCK),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({in_data, in_last}),
    .full  (hold_full_s),
    .dout  (hold_dout_s)
  );

  // Gap exit decode: next word index, frame end and whether a load happens now.
  always_comb begin
    idle_s      = 1'b0;
    advance_s   = 1'b0;
    to_fgap_s   = 1'b0;
    frame_end_s = 1'b0;
    load_idx_s  = word_cnt_r;
    case (state_r)
      ST_IDLE: begin
        idle_s = 1'b1;
      end
      ST_SHIFT: begin
        idle_s = 1'b0;
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          if (word_cnt_r != LAST_IDX) begin
            advance_s  = 1'b1;
            load_idx_s = word_cnt_r + CNT_W'(1);
          end else if (FRAME_GAP_CYC == 0) begin
            advance_s   = 1'b1;
            frame_end_s = 1'b1;
            load_idx_s  = '0;
          end else begin
            to_fgap_s = 1'b1;
          end
        end else begin
          advance_s = 1'b0;
        end
      end
      ST_FGAP: begin
        if (gap_cnt_r == FGAP_LAST) begin
          advance_s   = 1'b1;
          frame_end_s = 1'b1;
          load_idx_s  = '0;
        end else begin
          advance_s = 1'b0;
        end
      end
      default: begin
        idle_s = 1'b1;
      end
    endcase
    pop_s = hold_full_s & (idle_s | advance_s);
  end

  // Serializer FSM, counters, sticky frame check and registered driver outputs.
  always_ff @(posedge DCK or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      shift_r      <= '0;
      bit_cnt_r    <= '0;
      gap_cnt_r    <= '0;
      word_cnt_r   <= '0;
      den_r        <= 1'b0;
      dai_r        <= 1'b0;
      fgap_exit_r  <= 1'b0;
      frame_done_r <= 1'b0;
      sync_err_r   <= 1'b0;
    end else begin
      den_r        <= (state_r == ST_SHIFT);
      dai_r        <= (state_r == ST_SHIFT) & shift_r[0];
      fgap_exit_r  <= frame_end_s;
      frame_done_r <= fgap_exit_r;
      if (pop_s && frame_mismatch(hold_last_s, load_idx_s == LAST_IDX)) begin
        sync_err_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            shift_r   <= hold_word_s;
            bit_cnt_r <= '0;
            state_r   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shift_r <= shift_r >> 1;
          if (bit_cnt_r == LAST_BIT) begin
            bit_cnt_r <= '0;
            gap_cnt_r <= '0;
            state_r   <= ST_GAP;
          end else begin
            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
          end
        end
        ST_GAP, ST_FGAP: begin
          if (advance_s) begin
            word_cnt_r <= load_idx_s;
            gap_cnt_r  <= '0;
            if (pop_s) begin
              shift_r   <= hold_word_s;
              bit_cnt_r <= '0;
              state_r   <= ST_SHIFT;
            end else begin
              state_r <= ST_IDLE;
            end
          end else if (to_fgap_s) begin
            gap_cnt_r <= '0;
            state_r   <= ST_FGAP;
          end else begin
            gap_cnt_r <= gap_cnt_r + GCNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign DAI        = dai_r;
  assign DEN        = den_r;
  assign frame_done = frame_done_r;
  assign word_cnt   = word_cnt_r;
  assign sync_err   = sync_err_r;

endmodule
